// File: rtl/adma_dm_axi_aw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adma_dm_axi_aw                                                  |
// | Purpose  : AXI write-address issuer for the DMA datamover. Round-robin     |
// |            arbitrates per-channel write-burst requests, drives the AXI AW  |
// |            channel, pushes ordering info to the B-response and W-data      |
// |            stages and tracks per-channel outstanding writes.               |
// | Option   : define ADMA_AW_4KB_CHECK_EN to reject INCR bursts that cross a  |
// |            4 KB boundary (atx_bnd_err pulse instead of an AW).             |
// | Ports    : clk/rst            - clock, synchronous active-high reset      |
// |            atx_vld/atx_rdy    - per-channel request handshake             |
// |            atx_id/awaddr/awlen/awsize/awburst - per-channel request fields |
// |                                 (flattened, channel c at slice c)         |
// |            atx_done           - per-channel completion from B stage       |
// |            atx_bnd_err        - per-channel 4 KB reject pulse             |
// |            chn_ostd_idle      - per-channel "no writes outstanding"       |
// |            b_ord_* / w_ord_*  - order pushes to B and W stages            |
// |            m_aw*              - AXI AW master channel                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module adma_dm_axi_aw #(
   parameter int DMA_CHN_NUM   = 4,
   parameter int MST_ID_W      = 5,
   parameter int DST_ADDR_W    = 32,
   parameter int ATX_LEN_W     = 8,
   parameter int ATX_SIZE_W    = 3,
   parameter int ATX_BURST_W   = 2,
   parameter int CHN_OSTD_MAX  = 4,
   // derived, do not override
   parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DMA_CHN_NUM-1:0]             atx_vld,
   output logic [DMA_CHN_NUM-1:0]             atx_rdy,
   input  logic [DMA_CHN_NUM*MST_ID_W-1:0]    atx_id,
   input  logic [DMA_CHN_NUM*DST_ADDR_W-1:0]  atx_awaddr,
   input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]   atx_awlen,
   input  logic [DMA_CHN_NUM*ATX_SIZE_W-1:0]  atx_awsize,
   input  logic [DMA_CHN_NUM*ATX_BURST_W-1:0] atx_awburst,
   input  logic [DMA_CHN_NUM-1:0]             atx_done,
   output logic [DMA_CHN_NUM-1:0]             atx_bnd_err,
   output logic [DMA_CHN_NUM-1:0]             chn_ostd_idle,
   output logic [DMA_CHN_NUM_W-1:0]           b_ord_chn_id,
   output logic [MST_ID_W-1:0]                b_ord_awid,
   output logic                               b_ord_vld,
   input  logic                               b_ord_rdy,
   output logic [DMA_CHN_NUM_W-1:0]           w_ord_chn_id,
   output logic [ATX_LEN_W-1:0]               w_ord_len,
   output logic                               w_ord_vld,
   input  logic                               w_ord_rdy,
   output logic [MST_ID_W-1:0]                m_awid_o,
   output logic [DST_ADDR_W-1:0]              m_awaddr_o,
   output logic [ATX_LEN_W-1:0]               m_awlen_o,
   output logic [ATX_SIZE_W-1:0]              m_awsize_o,
   output logic [ATX_BURST_W-1:0]             m_awburst_o,
   output logic                               m_awvalid_o,
   input  logic                               m_awready_i
);

   localparam int                       OSTD_W     = $clog2(CHN_OSTD_MAX + 1);
   localparam logic [OSTD_W-1:0]        OSTD_MAX_V = OSTD_W'(CHN_OSTD_MAX);
   localparam logic [DMA_CHN_NUM_W-1:0] LAST_CHN   = DMA_CHN_NUM_W'(DMA_CHN_NUM - 1);
   localparam logic [DMA_CHN_NUM_W:0]   CHN_NUM_V  = (DMA_CHN_NUM_W + 1)'(DMA_CHN_NUM);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [DMA_CHN_NUM_W-1:0] rr_ptr;
   logic [OSTD_W-1:0]        ostd_cnt [DMA_CHN_NUM];
   logic [DMA_CHN_NUM-1:0]   elig;
   logic                     grant_vld;
   logic [DMA_CHN_NUM_W-1:0] grant;
   logic [DMA_CHN_NUM_W:0]   arb_idx;
   logic                     accept;
   logic                     issue;
   logic                     bnd_fail;

   logic [MST_ID_W-1:0]      sel_id;
   logic [DST_ADDR_W-1:0]    sel_addr;
   logic [ATX_LEN_W-1:0]     sel_len;
   logic [ATX_SIZE_W-1:0]    sel_size;
   logic [ATX_BURST_W-1:0]   sel_burst;

   // A channel competes only while it has room for another outstanding write.
   generate
      for (genvar c = 0; c < DMA_CHN_NUM; c++) begin : g_elig
         assign elig[c] = atx_vld[c] && (ostd_cnt[c] < OSTD_MAX_V);
      end
   endgenerate

   // Round-robin search: first eligible channel at or after rr_ptr, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      arb_idx   = '0;
      for (int i = 0; i < DMA_CHN_NUM; i++) begin
         arb_idx = {1'b0, rr_ptr} + (DMA_CHN_NUM_W + 1)'(i);
         if (arb_idx >= CHN_NUM_V) begin
            arb_idx = arb_idx - CHN_NUM_V;
         end
         if (!grant_vld && elig[arb_idx[DMA_CHN_NUM_W-1:0]]) begin
            grant_vld = 1'b1;
            grant     = arb_idx[DMA_CHN_NUM_W-1:0];
         end
      end
   end

   // Request-field mux for the granted channel.
   always_comb begin
      sel_id    = '0;
      sel_addr  = '0;
      sel_len   = '0;
      sel_size  = '0;
      sel_burst = '0;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
         if (grant == DMA_CHN_NUM_W'(c)) begin
            sel_id    = atx_id[c*MST_ID_W +: MST_ID_W];
            sel_addr  = atx_awaddr[c*DST_ADDR_W +: DST_ADDR_W];
            sel_len   = atx_awlen[c*ATX_LEN_W +: ATX_LEN_W];
            sel_size  = atx_awsize[c*ATX_SIZE_W +: ATX_SIZE_W];
            sel_burst = atx_awburst[c*ATX_BURST_W +: ATX_BURST_W];
         end
      end
   end

`ifdef ADMA_AW_4KB_CHECK_EN
   // Byte span can reach 256 << 7 = 32 KB, so 20 bits never overflow.
   logic [19:0] bnd_bytes;
   logic [19:0] bnd_end;

   assign bnd_bytes = (20'(sel_len) + 20'd1) << sel_size;
   assign bnd_end   = 20'(sel_addr[11:0]) + bnd_bytes;
   assign bnd_fail  = (sel_burst == ATX_BURST_W'(1)) && (bnd_end > 20'd4096);

   generate
      for (genvar c = 0; c < DMA_CHN_NUM; c++) begin : g_bnd_err
         assign atx_bnd_err[c] = accept && bnd_fail && (grant == DMA_CHN_NUM_W'(c));
      end
   endgenerate
`else
   assign bnd_fail    = 1'b0;
   assign atx_bnd_err = '0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and accept decision. Accepts only happen in IDLE, so the
   // AW handshake cycle can never also accept a new request.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && grant_vld && b_ord_rdy && w_ord_rdy) begin
               accept = 1'b1;
               if (!bnd_fail) begin
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (m_awready_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A rejected (boundary-crossing) accept consumes the request but issues nothing.
   assign issue = accept && !bnd_fail;

   generate
      for (genvar c = 0; c < DMA_CHN_NUM; c++) begin : g_rdy
         assign atx_rdy[c] = accept && (grant == DMA_CHN_NUM_W'(c));
      end
   endgenerate

   assign b_ord_vld    = issue;
   assign b_ord_chn_id = grant;
   assign b_ord_awid   = sel_id;
   assign w_ord_vld    = issue;
   assign w_ord_chn_id = grant;
   assign w_ord_len    = sel_len;

   // Valid comes straight from the state register: no path from m_awready_i.
   assign m_awvalid_o  = (state == ISSUE);

   always_ff @(posedge clk) begin
      if (rst) begin
         m_awid_o    <= '0;
         m_awaddr_o  <= '0;
         m_awlen_o   <= '0;
         m_awsize_o  <= '0;
         m_awburst_o <= '0;
      end else if (issue) begin
         m_awid_o    <= sel_id;
         m_awaddr_o  <= sel_addr;
         m_awlen_o   <= sel_len;
         m_awsize_o  <= sel_size;
         m_awburst_o <= sel_burst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant == LAST_CHN) ? '0 : grant + 1'b1;
      end
   end

   // Outstanding counters: a done at zero is spurious and ignored; a
   // simultaneous increment and decrement cancel out.
   generate
      for (genvar c = 0; c < DMA_CHN_NUM; c++) begin : g_ostd
         logic inc;
         logic dec;

         assign inc = issue && (grant == DMA_CHN_NUM_W'(c));
         assign dec = atx_done[c] && (ostd_cnt[c] != '0);

         always_ff @(posedge clk) begin
            if (rst) begin
               ostd_cnt[c] <= '0;
            end else if (inc && !dec) begin
               ostd_cnt[c] <= ostd_cnt[c] + 1'b1;
            end else if (dec && !inc) begin
               ostd_cnt[c] <= ostd_cnt[c] - 1'b1;
            end
         end

         assign chn_ostd_idle[c] = (ostd_cnt[c] == '0);
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_adma_dm_axi_aw.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_adma_dm_axi_aw                                               |
// | Purpose  : Self-checking bench for adma_dm_axi_aw: directed scenarios with |
// |            literal expectations plus randomized traffic compared every     |
// |            cycle against a behavioural model.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_adma_dm_axi_aw;

   localparam int N    = 4;
   localparam int IDW  = 5;
   localparam int AW   = 32;
   localparam int LW   = 8;
   localparam int SW   = 3;
   localparam int BW   = 2;
   localparam int OSTD = 2;
   localparam int CW   = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    atx_vld;
   logic [N-1:0]    atx_rdy;
   logic [N*IDW-1:0] atx_id;
   logic [N*AW-1:0] atx_awaddr;
   logic [N*LW-1:0] atx_awlen;
   logic [N*SW-1:0] atx_awsize;
   logic [N*BW-1:0] atx_awburst;
   logic [N-1:0]    atx_done;
   logic [N-1:0]    atx_bnd_err;
   logic [N-1:0]    chn_ostd_idle;
   logic [CW-1:0]   b_ord_chn_id;
   logic [IDW-1:0]  b_ord_awid;
   logic            b_ord_vld;
   logic            b_ord_rdy;
   logic [CW-1:0]   w_ord_chn_id;
   logic [LW-1:0]   w_ord_len;
   logic            w_ord_vld;
   logic            w_ord_rdy;
   logic [IDW-1:0]  m_awid_o;
   logic [AW-1:0]   m_awaddr_o;
   logic [LW-1:0]   m_awlen_o;
   logic [SW-1:0]   m_awsize_o;
   logic [BW-1:0]   m_awburst_o;
   logic            m_awvalid_o;
   logic            m_awready_i;

   adma_dm_axi_aw #(
      .DMA_CHN_NUM (N),
      .MST_ID_W    (IDW),
      .DST_ADDR_W  (AW),
      .ATX_LEN_W   (LW),
      .ATX_SIZE_W  (SW),
      .ATX_BURST_W (BW),
      .CHN_OSTD_MAX(OSTD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .atx_vld      (atx_vld),
      .atx_rdy      (atx_rdy),
      .atx_id       (atx_id),
      .atx_awaddr   (atx_awaddr),
      .atx_awlen    (atx_awlen),
      .atx_awsize   (atx_awsize),
      .atx_awburst  (atx_awburst),
      .atx_done     (atx_done),
      .atx_bnd_err  (atx_bnd_err),
      .chn_ostd_idle(chn_ostd_idle),
      .b_ord_chn_id (b_ord_chn_id),
      .b_ord_awid   (b_ord_awid),
      .b_ord_vld    (b_ord_vld),
      .b_ord_rdy    (b_ord_rdy),
      .w_ord_chn_id (w_ord_chn_id),
      .w_ord_len    (w_ord_len),
      .w_ord_vld    (w_ord_vld),
      .w_ord_rdy    (w_ord_rdy),
      .m_awid_o     (m_awid_o),
      .m_awaddr_o   (m_awaddr_o),
      .m_awlen_o    (m_awlen_o),
      .m_awsize_o   (m_awsize_o),
      .m_awburst_o  (m_awburst_o),
      .m_awvalid_o  (m_awvalid_o),
      .m_awready_i  (m_awready_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int g_q[$];
   int t_q[$];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [IDW-1:0] f_id(int c);
      return atx_id[c*IDW +: IDW];
   endfunction
   function automatic logic [AW-1:0] f_addr(int c);
      return atx_awaddr[c*AW +: AW];
   endfunction
   function automatic logic [LW-1:0] f_len(int c);
      return atx_awlen[c*LW +: LW];
   endfunction
   function automatic logic [SW-1:0] f_size(int c);
      return atx_awsize[c*SW +: SW];
   endfunction
   function automatic logic [BW-1:0] f_burst(int c);
      return atx_awburst[c*BW +: BW];
   endfunction

   // ---------------- behavioural model ----------------
   bit             m_busy;
   int             m_rr;
   int             m_cnt [N];
   logic [IDW-1:0] m_id;
   logic [AW-1:0]  m_addr;
   logic [LW-1:0]  m_len;
   logic [SW-1:0]  m_size;
   logic [BW-1:0]  m_burst;
   bit             e_acc;
   bit             e_bnd;
   int             e_g;
   int             e_c;
   logic [N-1:0]   e_idle;
   int             span;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_busy  = 0;
         m_rr    = 0;
         for (int c = 0; c < N; c++) m_cnt[c] = 0;
         m_id    = '0;
         m_addr  = '0;
         m_len   = '0;
         m_size  = '0;
         m_burst = '0;
      end else begin
         e_acc = 0;
         e_bnd = 0;
         e_g   = 0;
         if (!m_busy && b_ord_rdy && w_ord_rdy) begin
            for (int k = 0; k < N; k++) begin
               e_c = (m_rr + k) % N;
               if (!e_acc && atx_vld[e_c] && m_cnt[e_c] < OSTD) begin
                  e_acc = 1;
                  e_g   = e_c;
               end
            end
         end
`ifdef ADMA_AW_4KB_CHECK_EN
         span = (int'(f_addr(e_g)) & 'hFFF) + ((int'(f_len(e_g)) + 1) << f_size(e_g));
         if (e_acc && f_burst(e_g) == 2'b01 && span > 4096) e_bnd = 1;
`endif
         for (int c = 0; c < N; c++) e_idle[c] = (m_cnt[c] == 0);

         chk("atx_rdy", atx_rdy, e_acc ? (64'd1 << e_g) : 64'd0);
         chk("bnd_err", atx_bnd_err, (e_acc && e_bnd) ? (64'd1 << e_g) : 64'd0);
         chk("b_ord_vld", b_ord_vld, e_acc && !e_bnd);
         chk("w_ord_vld", w_ord_vld, e_acc && !e_bnd);
         if (e_acc && !e_bnd) begin
            chk("b_ord_chn", b_ord_chn_id, e_g);
            chk("b_ord_awid", b_ord_awid, f_id(e_g));
            chk("w_ord_chn", w_ord_chn_id, e_g);
            chk("w_ord_len", w_ord_len, f_len(e_g));
         end
         chk("awvalid", m_awvalid_o, m_busy);
         chk("aw_fields", {m_awid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o},
             {m_id, m_addr, m_len, m_size, m_burst});
         chk("ostd_idle", chn_ostd_idle, e_idle);

         if (atx_rdy != '0) begin
            g_q.push_back($clog2(atx_rdy));
            t_q.push_back(cyc);
         end

         // advance model to the state after the coming rising edge
         for (int c = 0; c < N; c++) begin
            if (atx_done[c] && m_cnt[c] > 0) m_cnt[c]--;
         end
         if (e_acc) begin
            m_rr = (e_g + 1) % N;
            if (!e_bnd) begin
               m_busy  = 1;
               m_id    = f_id(e_g);
               m_addr  = f_addr(e_g);
               m_len   = f_len(e_g);
               m_size  = f_size(e_g);
               m_burst = f_burst(e_g);
               m_cnt[e_g]++;
            end
         end else if (m_busy && m_awready_i) begin
            m_busy = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ch(int c, logic [IDW-1:0] id, logic [AW-1:0] addr,
                         logic [LW-1:0] len, logic [SW-1:0] size, logic [BW-1:0] burst);
      atx_id[c*IDW +: IDW]     = id;
      atx_awaddr[c*AW +: AW]   = addr;
      atx_awlen[c*LW +: LW]    = len;
      atx_awsize[c*SW +: SW]   = size;
      atx_awburst[c*BW +: BW]  = burst;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      atx_vld     = '0;
      atx_done    = '0;
      m_awready_i = 1'b0;
      b_ord_rdy   = 1'b1;
      w_ord_rdy   = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic std_fields();
      for (int c = 0; c < N; c++)
         set_ch(c, IDW'(c + 1), 32'h1000_0000 + AW'(c * 'h100), LW'(c + 1), 3'd2, 2'b01);
   endtask

   logic [AW-1:0] ra;

   initial begin
      rst = 1'b1;
      atx_vld = '0; atx_done = '0; atx_id = '0; atx_awaddr = '0;
      atx_awlen = '0; atx_awsize = '0; atx_awburst = '0;
      b_ord_rdy = 1'b1; w_ord_rdy = 1'b1; m_awready_i = 1'b0;
      do_reset();

      // reset state
      look();
      chk("rst_awvalid", m_awvalid_o, 0);
      chk("rst_idle", chn_ostd_idle, 4'hF);
      chk("rst_rdy", atx_rdy, 0);
      chk("rst_bvld", b_ord_vld, 0);
      chk("rst_awaddr", m_awaddr_o, 0);

      // single request on channel 0
      tick();
      set_ch(0, 5'd2, 32'h1000, 8'd3, 3'd5, 2'b01);
      atx_vld = 4'b0001;
      look();
      chk("single_rdy", atx_rdy, 4'b0001);
      chk("single_b", {b_ord_vld, b_ord_chn_id, b_ord_awid}, {1'b1, 2'd0, 5'd2});
      chk("single_w", {w_ord_vld, w_ord_chn_id, w_ord_len}, {1'b1, 2'd0, 8'd3});
      chk("single_awv_n", m_awvalid_o, 0);
      tick();
      atx_vld = '0;
      look();
      chk("single_awv", m_awvalid_o, 1);
      chk("single_aw", {m_awid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o},
          {5'd2, 32'h1000, 8'd3, 3'd5, 2'b01});
      chk("single_idle", chn_ostd_idle, 4'b1110);
      tick();
      m_awready_i = 1'b1;
      tick();
      m_awready_i = 1'b0;
      atx_done = 4'b0001;
      tick();
      atx_done = '0;
      look();
      chk("single_done_idle", chn_ostd_idle, 4'hF);

      // round robin with all channels requesting
      do_reset();
      std_fields();
      g_q.delete(); t_q.delete();
      atx_vld = 4'hF;
      m_awready_i = 1'b1;
      repeat (10) tick();
      atx_vld = '0;
      chk("rr_count", g_q.size(), 5);
      if (g_q.size() == 5) begin
         chk("rr_order", {g_q[0][1:0], g_q[1][1:0], g_q[2][1:0], g_q[3][1:0], g_q[4][1:0]},
             {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
         for (int i = 0; i < 4; i++) chk("rr_interval", t_q[i+1] - t_q[i], 2);
      end

      // AW back-pressure: fields stay stable, no further accepts
      do_reset();
      std_fields();
      g_q.delete();
      atx_vld = 4'hF;
      tick();
      repeat (5) begin
         look();
         chk("bp_awvalid", m_awvalid_o, 1);
         chk("bp_awaddr", m_awaddr_o, 32'h1000_0000);
         chk("bp_rdy", atx_rdy, 0);
         tick();
      end
      chk("bp_grants", g_q.size(), 1);
      m_awready_i = 1'b1;
      atx_vld = '0;
      tick();
      tick();

      // outstanding limit (2) on channel 1
      do_reset();
      std_fields();
      m_awready_i = 1'b1;
      g_q.delete();
      atx_vld = 4'b0010;
      repeat (8) tick();
      chk("ostd_stall", g_q.size(), 2);
      atx_done = 4'b0010;
      tick();
      atx_done = '0;
      repeat (6) tick();
      chk("ostd_third", g_q.size(), 3);
      atx_vld = '0;
      repeat (3) tick();
      atx_done = 4'b0010;
      tick();
      g_q.delete();
      atx_vld = 4'b0010;
      atx_done = 4'b0010;  // coincides with the next accept: count unchanged
      tick();
      atx_done = '0;
      repeat (8) tick();
      chk("ostd_same_cycle", g_q.size(), 2);
      atx_vld = '0;
      tick();

      // W order stage not ready: no accepts, pointer held
      do_reset();
      std_fields();
      m_awready_i = 1'b1;
      atx_vld = 4'b0001;
      tick();
      atx_vld = '0;
      tick();
      tick();
      g_q.delete();
      w_ord_rdy = 1'b0;
      atx_vld = 4'hF;
      repeat (6) tick();
      chk("wrdy_block", g_q.size(), 0);
      w_ord_rdy = 1'b1;
      repeat (3) tick();
      chk("wrdy_resume_n", g_q.size() > 0, 1);
      if (g_q.size() > 0) chk("wrdy_resume_g", g_q[0], 1);
      atx_vld = '0;
      tick();

`ifdef ADMA_AW_4KB_CHECK_EN
      // 4 KB boundary: exact fit issues, one byte-group over is rejected
      do_reset();
      m_awready_i = 1'b1;
      set_ch(0, 5'd3, 32'h0F80, 8'd3, 3'd5, 2'b01);
      atx_vld = 4'b0001;
      look();
      chk("bnd_fit_vld", b_ord_vld, 1);
      chk("bnd_fit_err", atx_bnd_err, 0);
      tick();
      atx_vld = '0;
      tick();
      tick();
      set_ch(0, 5'd3, 32'h0FA0, 8'd3, 3'd5, 2'b01);
      atx_vld = 4'b0001;
      look();
      chk("bnd_cross_rdy", atx_rdy, 4'b0001);
      chk("bnd_cross_err", atx_bnd_err, 4'b0001);
      chk("bnd_cross_bvld", b_ord_vld, 0);
      tick();
      atx_vld = '0;
      look();
      chk("bnd_cross_noaw", m_awvalid_o, 0);
      tick();
`endif

      // randomized traffic against the model
      do_reset();
      repeat (4000) begin
         rst = ($urandom_range(0, 499) == 0);
         for (int c = 0; c < N; c++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[11:8] = 4'hF;
            set_ch(c, IDW'($urandom), ra, LW'($urandom_range(0, 15)),
                   SW'($urandom_range(0, 5)), BW'($urandom_range(0, 2)));
            atx_vld[c] = ($urandom_range(0, 2) != 0);
            if (m_cnt[c] > 0) atx_done[c] = ($urandom_range(0, 2) == 0);
            else              atx_done[c] = !atx_vld[c] && ($urandom_range(0, 7) == 0);
         end
         b_ord_rdy   = ($urandom_range(0, 7) != 0);
         w_ord_rdy   = ($urandom_range(0, 7) != 0);
         m_awready_i = ($urandom_range(0, 2) != 0);
         tick();
      end
      rst = 1'b0;
      atx_vld = '0;
      atx_done = '0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
